// File: rtl/add_sub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : add_sub_arbiter (with helper Add_Sub)
//  Purpose  : Round-robin arbiter/sequencer sharing one carry-select Add_Sub
//             adder among NUM_REQ requesters. Subtract runs as two adder
//             passes (negate B, then add). Results leave through a
//             valid/ready port tagged with the requester index.
//  Option   : define ADD_SUB_ARB_SAT_EN to saturate results on overflow.
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  Add_Sub : carry-select adder, no carry-in. Low half ripples, the high half
//  is precomputed for both carries and selected by the low-half carry out.
// ----------------------------------------------------------------------------
module Add_Sub #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  ovf_o
);
  localparam int HALF = DATA_WIDTH / 2;

  logic [HALF:0]   w_lo;
  logic [HALF-1:0] w_hi0;
  logic [HALF-1:0] w_hi1;

  assign w_lo  = {1'b0, a_i[HALF-1:0]} + {1'b0, b_i[HALF-1:0]};
  assign w_hi0 = a_i[DATA_WIDTH-1:HALF] + b_i[DATA_WIDTH-1:HALF];
  assign w_hi1 = a_i[DATA_WIDTH-1:HALF] + b_i[DATA_WIDTH-1:HALF] + {{(HALF-1){1'b0}}, 1'b1};

  assign sum_o = {(w_lo[HALF] ? w_hi1 : w_hi0), w_lo[HALF-1:0]};
  // Signed overflow: operands share a sign that the sum does not.
  assign ovf_o = (a_i[DATA_WIDTH-1] == b_i[DATA_WIDTH-1]) &&
                 (sum_o[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);
endmodule

// ----------------------------------------------------------------------------
//  add_sub_arbiter : top level
// ----------------------------------------------------------------------------
module add_sub_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            sub,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] a_flat,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] b_flat,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic [DATA_WIDTH-1:0]         out_result,
  output logic                          out_overflow,
  output logic                          busy
);
  localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [ID_WIDTH-1:0]   LAST_IDX = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]    ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
`ifdef ADD_SUB_ARB_SAT_EN
  localparam logic [DATA_WIDTH-1:0] MAX_VAL  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NEG  = 2'd1,
    S_ADD  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0]   a_lat_q, a_lat_d;
  logic [DATA_WIDTH-1:0]   b_lat_q, b_lat_d;
  logic                    op_lat_q, op_lat_d;
  logic [ID_WIDTH-1:0]     id_lat_q, id_lat_d;
  logic                    bmin_q, bmin_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    ovf_q, ovf_d;
  logic [ID_WIDTH-1:0]     out_id_q, out_id_d;

  // Arbitration signals
  logic [2*NUM_REQ-1:0]    req_dbl;
  logic [NUM_REQ-1:0]      req_rot;
  logic                    sel_found;
  logic [ID_WIDTH-1:0]     sel_idx;
  logic [NUM_REQ-1:0]      sel_onehot;
  logic [DATA_WIDTH-1:0]   a_sel;
  logic [DATA_WIDTH-1:0]   b_sel;
  logic                    sub_sel;

  // Shared adder ports
  logic [DATA_WIDTH-1:0]   add_a;
  logic [DATA_WIDTH-1:0]   add_b;
  logic [DATA_WIDTH-1:0]   add_sum;
  logic                    add_ovf;

  // Rotate requests so bit 0 is the current highest-priority requester.
  assign req_dbl = {req, req} >> rr_ptr_q;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  // Pick the first requester at or after rr_ptr, wrapping around.
  always_comb begin
    int pos;
    pos       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!sel_found && req_rot[k]) begin
        sel_found = 1'b1;
        pos       = int'(rr_ptr_q) + k;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        sel_idx   = pos[ID_WIDTH-1:0];
      end
    end
  end

  assign sel_onehot = ONE_HOT0 << sel_idx;

  // Route the selected requester's operands and opcode.
  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    sub_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_onehot[i]) begin
        a_sel   = a_flat[i*DATA_WIDTH +: DATA_WIDTH];
        b_sel   = b_flat[i*DATA_WIDTH +: DATA_WIDTH];
        sub_sel = sub[i];
      end
    end
  end

  // Adder operand mux: NEG pass forms ~B + 1, every other state adds A + B.
  always_comb begin
    add_a = a_lat_q;
    add_b = b_lat_q;
    if (state_q == S_NEG) begin
      add_a = ~b_lat_q;
      add_b = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  Add_Sub #(.DATA_WIDTH(DATA_WIDTH)) u_add_sub (
    .a_i   (add_a),
    .b_i   (add_b),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    a_lat_d  = a_lat_q;
    b_lat_d  = b_lat_q;
    op_lat_d = op_lat_q;
    id_lat_d = id_lat_q;
    bmin_d   = bmin_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    out_id_d = out_id_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          a_lat_d  = a_sel;
          b_lat_d  = b_sel;
          op_lat_d = sub_sel;
          id_lat_d = sel_idx;
          bmin_d   = 1'b0;
          rr_ptr_d = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
          state_d  = sub_sel ? S_NEG : S_ADD;
        end
      end
      S_NEG: begin
        // Negating the most negative value wraps to itself; remember it so
        // the overflow flag can be corrected in the add pass.
        bmin_d  = (b_lat_q == MIN_VAL);
        b_lat_d = add_sum;
        state_d = S_ADD;
      end
      S_ADD: begin
        ovf_d    = (op_lat_q && bmin_q) ? ~a_lat_q[DATA_WIDTH-1] : add_ovf;
        result_d = add_sum;
`ifdef ADD_SUB_ARB_SAT_EN
        // Overflow direction follows the sign of A (effective operands agree).
        if (ovf_d) result_d = a_lat_q[DATA_WIDTH-1] ? MIN_VAL : MAX_VAL;
`endif
        out_id_d = id_lat_q;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Operand latches, round-robin pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      a_lat_q  <= '0;
      b_lat_q  <= '0;
      op_lat_q <= 1'b0;
      id_lat_q <= '0;
      bmin_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      out_id_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      a_lat_q  <= a_lat_d;
      b_lat_q  <= b_lat_d;
      op_lat_q <= op_lat_d;
      id_lat_q <= id_lat_d;
      bmin_q   <= bmin_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      out_id_q <= out_id_d;
    end
  end

  // Grant is a combinational pulse in IDLE, forced low while reset is held.
  assign gnt          = (rst_n && state_q == S_IDLE && sel_found) ? sel_onehot : '0;
  assign out_valid    = (state_q == S_OUT);
  assign busy         = (state_q != S_IDLE);
  assign out_id       = out_id_q;
  assign out_result   = result_q;
  assign out_overflow = ovf_q;

endmodule
`default_nettype wire

// File: doc/add_sub_arbiter.md
# add_sub_arbiter

Round-robin arbiter and sequencer that shares one `Add_Sub` carry-select adder instance among `NUM_REQ` ODE-solver datapath requesters. Each request is an add or a subtract. The shared adder has no carry-in or subtract control, so the block performs a subtract as two adder passes: it first negates B, then adds. Results return through a registered valid/ready output tagged with the requester index.

## Interface
- `DATA_WIDTH`, 16, operand/result width; even, passed to `Add_Sub`.
- `NUM_REQ`, 4, number of requesters; 2..8.
- `ID_WIDTH`, 2, width of `out_id`; must be ≥ clog2(`NUM_REQ`).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester request; held until the matching `gnt` bit.
- `sub`  in  NUM_REQ  per-requester op: 1 = A−B, 0 = A+B.
- `a_flat`  in  NUM_REQ*DATA_WIDTH  operand A; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `b_flat`  in  NUM_REQ*DATA_WIDTH  operand B; same packing as `a_flat`.
- `gnt`  out  NUM_REQ  one-hot, one-cycle pulse; operands sampled that cycle.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_id`  out  ID_WIDTH  index of the requester that owns the result.
- `out_result`  out  DATA_WIDTH  two's-complement result.
- `out_overflow`  out  1  signed overflow of the requested operation.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Exactly one `Add_Sub` instance. Its operand inputs are muxed by the FSM.
- Operand latches: `a_lat`, `b_lat`, `op_lat`, `id_lat`. Round-robin pointer `rr_ptr`.
- FSM states:
  - IDLE:
    - If any `req`: pick the first set bit scanning upward from `rr_ptr` with wrap.
    - Pulse that `gnt` bit, latch the requester's A, B, `sub` and index.
    - Set `rr_ptr` = granted index + 1, mod NUM_REQ.
    - Go to NEG if `sub`, else ADD.
  - NEG:
    - Adder inputs are (~`b_lat`, 1). Store the sum into `b_lat`.
    - Set `bmin` = (`b_lat` == 100…0), captured before the overwrite.
    - Go to ADD.
  - ADD:
    - Adder inputs are (`a_lat`, `b_lat`). Register the sum into `out_result` and the adder overflow into `out_overflow`.
    - Exception: if `op_lat` and `bmin`, force `out_overflow` = ~`a_lat`[MSB].
    - Go to OUT.
  - OUT:
    - `out_valid` = 1. Result, id and overflow stay stable.
    - On `out_valid` & `out_ready`, go to IDLE.
- No grant is issued outside IDLE. Requests wait without loss.
- Arithmetic:
  - All values are signed, DATA_WIDTH bits, result wraps modulo 2^DATA_WIDTH.
  - Overflow = operand signs equal and result sign differs, computed on the effective operands.
- Bits of `req` are ignored when index ≥ NUM_REQ (not applicable), and a `req` that drops before its grant is simply not served.
- Reset mid-operation:
  - State returns to IDLE, `rr_ptr` = 0, and all outputs return to their reset values.
  - The in-flight transaction is discarded. The requester must re-request.

## Timing
- Reset values:
  - `gnt` = 0, `out_valid` = 0, `out_id` = 0, `out_result` = 0, `out_overflow` = 0, `busy` = 0.
  - `rr_ptr` = 0, so requester 0 has highest priority.
- Grant in cycle T (IDLE):
  - Add: `out_valid` rises at T+2.
  - Subtract: `out_valid` rises at T+3.
- Handshake at cycle H: `out_valid` falls at H+1 and the state is IDLE at H+1. The next `gnt` comes no earlier than H+1.
- Peak throughput: one add per 3 cycles, one subtract per 4 cycles.
- `busy` is high from T+1 through the handshake cycle.

## Configuration
- `ADD_SUB_ARB_SAT_EN` defined:
  - In ADD, when overflow is detected, `out_result` saturates: to 011…1 if the true result is positive (effective operand signs 0), to 100…0 if negative.
  - `out_overflow` still reports 1.
- Not defined: `out_result` is the wrapped sum. Overflow is reported only.

## Test plan
- Single add: req[0], A=0x0005, B=0x0003, sub=0.
  - → gnt[0] at T; out_valid at T+2 with result 0x0008, id 0, ovf 0.
- Single sub: req[2], A=0x0003, B=0x0005.
  - → out_valid at T+3 with result 0xFFFE, id 2, ovf 0.
- Overflow: A=0x7FFF, B=0x0001, add.
  - → ovf 1, result 0x8000 (0x7FFF with `ADD_SUB_ARB_SAT_EN`).
  - Sub A=0x0000, B=0x8000 → ovf 1.
- Round-robin: all four req held high, out_ready tied 1.
  - → grants in order 0, 1, 2, 3, 0. No requester is granted twice before the others.
- Backpressure: out_ready=0 for 5 cycles after out_valid.
  - → result, id and ovf stable; no gnt while pending requests wait.
  - Raise out_ready → next gnt one cycle after the handshake.
- Reset during NEG: assert rst_n=0.
  - → all outputs 0 immediately (asynchronous).
  - After release, the re-held req[1] is granted and completes correctly.
